// File: rtl/ip_pkg.sv
// Shared IPv4 header constants and the header-checker state encoding.
package ip_pkg;

    localparam logic [3:0] IP_VER4 = 4'd4;
    localparam logic [3:0] IHL_MIN = 4'd5;

    // Byte offsets of captured fields within the header.
    localparam logic [5:0] OFF_TOT_LEN = 6'd2;
    localparam logic [5:0] OFF_PROTO   = 6'd9;
    localparam logic [5:0] OFF_SRC     = 6'd12;
    localparam logic [5:0] OFF_DST     = 6'd16;

    // A header with IHL below the minimum still consumes a minimal header.
    localparam logic [5:0] MIN_HDR_BYTES = 6'd20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/ip_hdr_check_csum_acc.sv
// csum_acc: one's-complement checksum accumulator for 16-bit words.
// Words are summed into a 32-bit register; the sum is folded twice and
// a header is valid when the folded result is all ones.
module csum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        word_vld,
    input  logic [15:0] word,
    output logic        pass
);

    logic [31:0] acc_q, acc_d;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Next accumulator value: clear wins over add.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (word_vld) begin
            acc_d = acc_q + {16'd0, word};
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Two folds bring any 32-bit sum down to 16 bits without further carry.
    always_comb begin
        fold1 = {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        pass  = (fold2 == 16'hFFFF);
    end

endmodule

// File: rtl/ip_hdr_check.sv
// ip_hdr_check: streaming IPv4 header checker. Consumes 4*IHL header bytes,
// captures protocol/length/addresses, and verifies version, IHL and checksum.
// Build option: IP_HDR_CHK_OPT_EN accepts IHL 5..15 (options summed);
// without it any IHL other than 5 is consumed but reported as an error.
//
// state    | meaning
// ST_IDLE  | waiting for din_sop
// ST_HDR   | accepting header bytes, counting to 4*IHL-1
// ST_CHECK | header complete, hdr_done pulses with the result
module ip_hdr_check
    import ip_pkg::*;
#(
    parameter logic [31:0] LOCAL_IP = 32'hC0A8_00C7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_vld,
    input  logic        din_sop,
    output logic        hdr_done,
    output logic        hdr_ok,
    output logic        hdr_err,
    output logic [7:0]  protocol,
    output logic [15:0] tot_len,
    output logic [3:0]  hdr_len,
    output logic [31:0] src_ip,
    output logic [31:0] dst_ip,
    output logic        dst_match
);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  last_q, last_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic        fmt_ok_q, fmt_ok_d;
    logic        hdr_done_q, hdr_done_d;
    logic [7:0]  protocol_q, protocol_d;
    logic [15:0] tot_len_q, tot_len_d;
    logic [3:0]  hdr_len_q, hdr_len_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;

    logic        accept_sop, accept_byte;
    logic        csum_clr, word_vld, csum_pass;
    logic [5:0]  len_bytes;

    csum_acc u_csum_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (csum_clr),
        .word_vld (word_vld),
        .word     ({hi_byte_q, din}),
        .pass     (csum_pass)
    );

    // Next-state, byte counting, word pairing and field capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        hi_byte_d  = hi_byte_q;
        fmt_ok_d   = fmt_ok_q;
        hdr_done_d = 1'b0;
        protocol_d = protocol_q;
        tot_len_d  = tot_len_q;
        hdr_len_d  = hdr_len_q;
        src_ip_d   = src_ip_q;
        dst_ip_d   = dst_ip_q;
        csum_clr   = 1'b0;
        word_vld   = 1'b0;
        len_bytes  = (din[3:0] < IHL_MIN) ? MIN_HDR_BYTES : {din[3:0], 2'b00};

        accept_sop  = din_vld && din_sop;
        accept_byte = din_vld && !din_sop && (state_q == ST_HDR);

        if (state_q == ST_CHECK) begin
            state_d = ST_IDLE;
        end

        if (accept_sop) begin
            // Byte 0 always restarts, abandoning any header in flight.
            state_d   = ST_HDR;
            cnt_d     = 6'd1;
            last_d    = len_bytes - 6'd1;
            hi_byte_d = din;
            hdr_len_d = din[3:0];
            csum_clr  = 1'b1;
`ifdef IP_HDR_CHK_OPT_EN
            fmt_ok_d  = (din[7:4] == IP_VER4) && (din[3:0] >= IHL_MIN);
`else
            fmt_ok_d  = (din[7:4] == IP_VER4) && (din[3:0] == IHL_MIN);
`endif
        end else if (accept_byte) begin
            cnt_d = cnt_q + 6'd1;
            if (!cnt_q[0]) begin
                hi_byte_d = din;
            end else begin
                word_vld = 1'b1;
            end
            if (cnt_q == OFF_TOT_LEN || cnt_q == OFF_TOT_LEN + 6'd1) begin
                tot_len_d = {tot_len_q[7:0], din};
            end
            if (cnt_q == OFF_PROTO) begin
                protocol_d = din;
            end
            if (cnt_q >= OFF_SRC && cnt_q < OFF_DST) begin
                src_ip_d = {src_ip_q[23:0], din};
            end
            if (cnt_q >= OFF_DST && cnt_q < OFF_DST + 6'd4) begin
                dst_ip_d = {dst_ip_q[23:0], din};
            end
            if (cnt_q == last_q) begin
                state_d    = ST_CHECK;
                hdr_done_d = 1'b1;
            end
        end
    end

    // Single state/datapath register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            hi_byte_q  <= '0;
            fmt_ok_q   <= 1'b0;
            hdr_done_q <= 1'b0;
            protocol_q <= '0;
            tot_len_q  <= '0;
            hdr_len_q  <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            hi_byte_q  <= hi_byte_d;
            fmt_ok_q   <= fmt_ok_d;
            hdr_done_q <= hdr_done_d;
            protocol_q <= protocol_d;
            tot_len_q  <= tot_len_d;
            hdr_len_q  <= hdr_len_d;
            src_ip_q   <= src_ip_d;
            dst_ip_q   <= dst_ip_d;
        end
    end

    // Result flags are only meaningful during the hdr_done pulse.
    assign hdr_done  = hdr_done_q;
    assign hdr_ok    = hdr_done_q && fmt_ok_q && csum_pass;
    assign hdr_err   = hdr_done_q && !hdr_ok;
    assign dst_match = hdr_done_q && (dst_ip_q == LOCAL_IP);
    assign protocol  = protocol_q;
    assign tot_len   = tot_len_q;
    assign hdr_len   = hdr_len_q;
    assign src_ip    = src_ip_q;
    assign dst_ip    = dst_ip_q;

endmodule

// File: doc/ip_hdr_check.md
IP_HDR_CHECK -- requirements
Module: ip_hdr_check

Interface
REQ-001 The module SHALL have parameter LOCAL_IP, default 32'hC0A8_00C7, the station IPv4 address compared against the header destination.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port din, input, 8, header byte stream, network byte order.
REQ-005 The module SHALL have port din_vld, input, 1, din valid this cycle.
REQ-006 The module SHALL have port din_sop, input, 1, qualified by din_vld; marks byte 0 (version/IHL).
REQ-007 The module SHALL have port hdr_done, output, 1, one-cycle pulse: header fully received, result valid.
REQ-008 The module SHALL have port hdr_ok, output, 1, valid with hdr_done: version 4, IHL legal, checksum correct.
REQ-009 The module SHALL have port hdr_err, output, 1, valid with hdr_done: the complement of hdr_ok.
REQ-010 The module SHALL have ports protocol (8), tot_len (16), hdr_len (4), src_ip (32), dst_ip (32), outputs, captured header fields, stable from hdr_done until the next din_sop.
REQ-011 The module SHALL have port dst_match, output, 1, valid with hdr_done: dst_ip equals LOCAL_IP.

Function
REQ-012 The module SHALL implement states IDLE, HDR, CHECK; IDLE->HDR on din_vld&din_sop; HDR->CHECK on acceptance of byte 4*IHL-1; CHECK->IDLE unconditionally after one cycle.
REQ-013 The module SHALL count accepted bytes with a 6-bit counter cleared on din_sop; cycles without din_vld SHALL hold all state.
REQ-014 The module SHALL pair bytes into 16-bit words (even byte high) and add each word, checksum field included, into a 32-bit accumulator.
REQ-015 In CHECK the module SHALL fold the accumulator twice (high half plus low half); the header passes when the folded 16-bit result equals 16'hFFFF.
REQ-016 The module SHALL pulse hdr_done in CHECK, exactly one cycle after the last header byte is accepted.
REQ-017 The module SHALL flag an error when version is not 4 or IHL is less than 5; the remaining 4*IHL bytes SHALL still be consumed (IHL<5 consumes 20 bytes).
REQ-018 The module SHALL treat din_sop during HDR as abandoning the current header, with no hdr_done for it, and SHALL restart with that byte as byte 0.
REQ-019 The module SHALL ignore din_vld bytes without din_sop while in IDLE or CHECK.

Reset
REQ-020 The module SHALL, on rst, enter IDLE, clear the counter and accumulator, and drive every output to 0, including mid-header.
REQ-021 The module SHALL not emit hdr_done for a header interrupted by reset.

Configuration
REQ-022 With IP_HDR_CHK_OPT_EN defined, the module SHALL accept IHL 5..15 and include option words in the sum.
REQ-023 Without IP_HDR_CHK_OPT_EN, the module SHALL consume 4*IHL bytes for any IHL>5 but SHALL report hdr_err.

Structure
REQ-024 Shared package ip_pkg SHALL hold IP_VER4=4, IHL_MIN=5, the state enumeration, and the byte-offset constants for protocol (9), src_ip (12), and dst_ip (16).
REQ-025 The module SHALL instantiate one sub-module, csum_acc, holding the 32-bit accumulator, the fold, and the pass compare; csum_acc is shared with future checksum users.

Verification
REQ-026 The bench SHALL send 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7 -> hdr_done one cycle after the last byte, hdr_ok=1, protocol=8'h11, tot_len=16'h0073, dst_match=1.
REQ-027 The bench SHALL send the same header with byte 11 = 8'h62 -> hdr_err=1, hdr_ok=0, and all fields still captured.
REQ-028 The bench SHALL send the first byte 8'h65 with a corrected checksum -> hdr_err=1 (version 6).
REQ-029 The bench SHALL send the first header with din_vld deasserted every other cycle -> identical result, hdr_done 1 cycle after the 20th accepted byte.
REQ-030 The bench SHALL abort after 10 bytes with din_sop and then send a full header -> exactly one hdr_done, for the second header only.
REQ-031 The bench SHALL send 46 xx with a 4-byte option and a correct checksum -> hdr_ok=1 after 24 bytes with IP_HDR_CHK_OPT_EN, and hdr_err=1 after 24 bytes without it.
